w0rm_peripheral_mem_arbiter: RTL and testbench
==============================================

W0RM_PERIPHERAL_MEM_ARBITER -- requirements
Module: w0rm_peripheral_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data width.
REQ-003 SHALL have parameter USER_WIDTH, default 32, user sideband width.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 16, wait cycles before error response.
REQ-005 SHALL have port mem_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port cpu_reset, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports mX_valid_i / mX_read_i / mX_write_i (X=0,1), input, 1 each, master X request qualifiers.
REQ-008 SHALL have ports mX_addr_i, input, ADDR_WIDTH, master X address.
REQ-009 SHALL have ports mX_data_i, input, DATA_WIDTH, master X write data.
REQ-010 SHALL have ports mX_user_i, input, USER_WIDTH, master X sideband.
REQ-011 SHALL have ports mX_ready_o, output, 1, request accepted this cycle.
REQ-012 SHALL have ports mX_valid_o / mX_err_o, output, 1 each, response strobe / timeout flag.
REQ-013 SHALL have ports mX_data_o, output, DATA_WIDTH, response data; mX_user_o, output, USER_WIDTH, echoed sideband.
REQ-014 SHALL have ports mem_valid_o / mem_read_o / mem_write_o, output, 1 each, downstream memory request.
REQ-015 SHALL have ports mem_addr_o, output, ADDR_WIDTH; mem_data_o, output, DATA_WIDTH; mem_user_o, output, USER_WIDTH.
REQ-016 SHALL have ports mem_valid_i, input, 1; mem_data_i, input, DATA_WIDTH; mem_user_i, input, USER_WIDTH; memory response.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT, RESP; exactly one transaction outstanding.
REQ-018 In IDLE, a request is mX_valid_i && (mX_read_i || mX_write_i); mX_ready_o SHALL be combinationally high only for the granted master in IDLE.
REQ-019 Arbitration SHALL be round-robin: single requester wins; on contention, the master not granted last wins.
REQ-020 On acceptance (cycle N) SHALL register request fields and grant ID; go to ISSUE.
REQ-021 In ISSUE (cycle N+1) mem_valid_o SHALL be high exactly one cycle with registered fields; go to WAIT.
REQ-022 In WAIT, mem_valid_i SHALL capture mem_data_i / mem_user_i; go to RESP.
REQ-023 In RESP, granted mX_valid_o SHALL pulse one cycle with data/user; other master's outputs stay 0; go to IDLE (nominal response at N+3).
REQ-024 Back-to-back accepts SHALL occur no faster than every 4 cycles; mem_valid_i outside WAIT SHALL be ignored.
REQ-025 mem_valid_o, mX_valid_o, mX_err_o SHALL be 0 in every state not listed above.
REQ-026 Write transactions SHALL also wait for and forward the memory acknowledge.

Reset
REQ-027 cpu_reset SHALL force IDLE, all outputs 0, last-grant = master 1 (master 0 wins first contention).
REQ-028 Reset mid-transaction SHALL abort it; no response delivered; a later stray mem_valid_i ignored.

Configuration
REQ-029 Macro W0RM_MEM_ARB_TIMEOUT_EN defined: counter in WAIT; after TIMEOUT_CYCLES cycles without mem_valid_i go to RESP with mX_err_o=1, data 0, registered user echoed.
REQ-030 Macro undefined: no counter; WAIT persists until mem_valid_i; mX_err_o tied 0.

Structure
REQ-031 Package w0rm_mem_arb_pkg SHALL hold state encoding and master ID constants (M0=0, M1=1).
REQ-032 Grant logic SHALL be sub-module w0rm_rr_arbiter2 (req[1:0], last grant in, grant one-hot out).

Verification
REQ-033 m0 read addr 0x4000_0004 alone -> mem_valid_o at N+1, mem_valid_i data 0xDEAD_BEEF -> m0_valid_o=1, m0_data_o=0xDEAD_BEEF at N+3.
REQ-034 m0 and m1 request same cycle after reset -> m0 granted first, m1 next accept 4 cycles later; repeat -> alternation.
REQ-035 m1 write 0x1234_5678, user 0xA5 -> mem_write_o=1, mem_data_o=0x1234_5678; m1_user_o=0xA5 on response.
REQ-036 With macro, addr 0x0000_0000 (no memory response) -> m0_err_o=1, m0_data_o=0 after 16 WAIT cycles; without, stays WAIT.
REQ-037 cpu_reset asserted during WAIT, mem_valid_i one cycle later -> no mX_valid_o; arbiter in IDLE, next request accepted normally.

Source files
------------

// File: rtl/w0rm_mem_arb_pkg.sv
// Shared types for the two-master peripheral memory arbiter: FSM state
// encoding and master ID constants.
package w0rm_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/w0rm_rr_arbiter2.sv
// Two-way round-robin grant: a lone requester wins; on contention the
// master that did not win last time is granted.
module w0rm_rr_arbiter2
  import w0rm_mem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    case (req_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (last_grant_i == M0) ? 2'b10 : 2'b01;
      default: grant_o = 2'b00;
    endcase
  end

endmodule

// File: rtl/w0rm_peripheral_mem_arbiter.sv
// Two-master to one-memory arbiter, one transaction in flight (IDLE/ISSUE/WAIT/RESP).
// Define W0RM_MEM_ARB_TIMEOUT_EN to add a WAIT-state timeout with error response.
module w0rm_peripheral_mem_arbiter
  import w0rm_mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int USER_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  mem_clk,
  input  logic                  cpu_reset,
  input  logic                  m0_valid_i,
  input  logic                  m0_read_i,
  input  logic                  m0_write_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_data_i,
  input  logic [USER_WIDTH-1:0] m0_user_i,
  output logic                  m0_ready_o,
  output logic                  m0_valid_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_data_o,
  output logic [USER_WIDTH-1:0] m0_user_o,
  input  logic                  m1_valid_i,
  input  logic                  m1_read_i,
  input  logic                  m1_write_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_data_i,
  input  logic [USER_WIDTH-1:0] m1_user_i,
  output logic                  m1_ready_o,
  output logic                  m1_valid_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_data_o,
  output logic [USER_WIDTH-1:0] m1_user_o,
  output logic                  mem_valid_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [USER_WIDTH-1:0] mem_user_o,
  input  logic                  mem_valid_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  input  logic [USER_WIDTH-1:0] mem_user_i
);

  if (TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  id_q, id_d;
  logic                  rd_q, rd_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [USER_WIDTH-1:0] user_q, user_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [USER_WIDTH-1:0] ruser_q, ruser_d;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  logic [1:0] req, gnt;
  logic       idle, accept, sel, issue, resp;

  assign req = {m1_valid_i & (m1_read_i | m1_write_i),
                m0_valid_i & (m0_read_i | m0_write_i)};

  w0rm_rr_arbiter2 u_rr_arbiter2 (
    .req_i        (req),
    .last_grant_i (last_q),
    .grant_o      (gnt)
  );

  // Ready is combinational, so it is masked while reset is held.
  assign idle       = (state_q == IDLE) & ~cpu_reset;
  assign accept     = idle & (|gnt);
  assign sel        = gnt[1] ? M1 : M0;
  assign m0_ready_o = idle & gnt[0];
  assign m1_ready_o = idle & gnt[1];

  always_comb begin
    // NOTE: every *_d gets its hold value first so no path through this block infers a latch.
    state_d = state_q;
    last_d  = last_q;
    id_d    = id_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    user_d  = user_q;
    rdata_d = rdata_q;
    ruser_d = ruser_q;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    err_d   = err_q;
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          id_d    = sel;
          last_d  = sel;
          rd_d    = (sel == M1) ? m1_read_i  : m0_read_i;
          wr_d    = (sel == M1) ? m1_write_i : m0_write_i;
          addr_d  = (sel == M1) ? m1_addr_i  : m0_addr_i;
          wdata_d = (sel == M1) ? m1_data_i  : m0_data_i;
          user_d  = (sel == M1) ? m1_user_i  : m0_user_i;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      WAIT: begin
        if (mem_valid_i) begin
          rdata_d = mem_data_i;
          ruser_d = mem_user_i;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = RESP;
        end
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = '0;
          ruser_d = user_q;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: synchronous reset; all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge mem_clk) begin
    if (cpu_reset) begin
      state_q <= IDLE;
      last_q  <= M1;
      id_q    <= M0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      user_q  <= '0;
      rdata_q <= '0;
      ruser_q <= '0;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
      err_q   <= 1'b0;
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      user_q  <= user_d;
      rdata_q <= rdata_d;
      ruser_q <= ruser_d;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign issue       = (state_q == ISSUE);
  assign resp        = (state_q == RESP);
  assign mem_valid_o = issue;
  assign mem_read_o  = issue & rd_q;
  assign mem_write_o = issue & wr_q;
  assign mem_addr_o  = issue ? addr_q  : '0;
  assign mem_data_o  = issue ? wdata_q : '0;
  assign mem_user_o  = issue ? user_q  : '0;

  assign m0_valid_o = resp & (id_q == M0);
  assign m1_valid_o = resp & (id_q == M1);
  assign m0_data_o  = m0_valid_o ? rdata_q : '0;
  assign m1_data_o  = m1_valid_o ? rdata_q : '0;
  assign m0_user_o  = m0_valid_o ? ruser_q : '0;
  assign m1_user_o  = m1_valid_o ? ruser_q : '0;
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
  assign m0_err_o   = m0_valid_o & err_q;
  assign m1_err_o   = m1_valid_o & err_q;
`else
  assign m0_err_o   = 1'b0;
  assign m1_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_w0rm_peripheral_mem_arbiter.sv
// Scoreboard bench for w0rm_peripheral_mem_arbiter; expected memory requests and
// master responses are queued at stimulus time and popped by a negedge monitor.
module tb_w0rm_peripheral_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int UW = 32;
  localparam int TO = 16;

  typedef struct packed {
    logic          id;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
    logic          err;
  } rsp_t;

  typedef struct packed {
    logic          rd;
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [UW-1:0] user;
  } mreq_t;

  logic          mem_clk = 1'b0;
  logic          cpu_reset;
  logic [1:0]    mv, mrd, mwr;
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdata[2];
  logic [UW-1:0] muser [2];
  logic          m0_ready_o, m0_valid_o, m0_err_o, m1_ready_o, m1_valid_o, m1_err_o;
  logic [DW-1:0] m0_data_o, m1_data_o;
  logic [UW-1:0] m0_user_o, m1_user_o;
  logic          mem_valid_o, mem_read_o, mem_write_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_data_o;
  logic [UW-1:0] mem_user_o;
  logic          mem_valid_i;
  logic [DW-1:0] mem_data_i;
  logic [UW-1:0] mem_user_i;

  rsp_t  rsp_q[$];
  mreq_t mreq_q[$];
  int    checks   = 0;
  int    failures = 0;

  wire [1:0] mready = {m1_ready_o, m0_ready_o};
  wire [1:0] mvo    = {m1_valid_o, m0_valid_o};
  wire [1:0] merr   = {m1_err_o, m0_err_o};

  always #5 mem_clk = ~mem_clk;

  w0rm_peripheral_mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .mem_clk(mem_clk), .cpu_reset(cpu_reset),
    .m0_valid_i(mv[0]), .m0_read_i(mrd[0]), .m0_write_i(mwr[0]),
    .m0_addr_i(maddr[0]), .m0_data_i(mwdata[0]), .m0_user_i(muser[0]),
    .m0_ready_o(m0_ready_o), .m0_valid_o(m0_valid_o), .m0_err_o(m0_err_o),
    .m0_data_o(m0_data_o), .m0_user_o(m0_user_o),
    .m1_valid_i(mv[1]), .m1_read_i(mrd[1]), .m1_write_i(mwr[1]),
    .m1_addr_i(maddr[1]), .m1_data_i(mwdata[1]), .m1_user_i(muser[1]),
    .m1_ready_o(m1_ready_o), .m1_valid_o(m1_valid_o), .m1_err_o(m1_err_o),
    .m1_data_o(m1_data_o), .m1_user_o(m1_user_o),
    .mem_valid_o(mem_valid_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o), .mem_user_o(mem_user_o),
    .mem_valid_i(mem_valid_i), .mem_data_i(mem_data_i), .mem_user_i(mem_user_i)
  );

  task automatic cyc();
    @(posedge mem_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge mem_clk);
  endtask

  task automatic set_req(input int m, input logic rd, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [UW-1:0] u);
    mv[m] = 1'b1; mrd[m] = rd; mwr[m] = wr;
    maddr[m] = a; mwdata[m] = d; muser[m] = u;
  endtask

  task automatic clr_req(input int m);
    mv[m] = 1'b0; mrd[m] = 1'b0; mwr[m] = 1'b0;
    maddr[m] = '0; mwdata[m] = '0; muser[m] = '0;
  endtask

  task automatic do_reset();
    cyc(); cpu_reset = 1'b1;
    cyc(); cyc(); cpu_reset = 1'b0;
  endtask

  // Drives cycles N+1..N+3 after an accept: release, memory reply, reply removal.
  task automatic serve(input logic [1:0] rel, input logic [DW-1:0] d, input logic [UW-1:0] u);
    cyc(); if (rel[0]) clr_req(0); if (rel[1]) clr_req(1);
    smp();
    cyc(); mem_valid_i = 1'b1; mem_data_i = d; mem_user_i = u;
    smp();
    cyc(); mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    smp();
  endtask

  task automatic monitor();
    rsp_t  e, got;
    mreq_t me, mg;
    forever begin
      @(negedge mem_clk);
      if (mvo != 2'b00) begin
        checks++;
        if (mvo == 2'b11 || rsp_q.size() == 0) begin
          failures++;
          $display("FAIL rsp_unexpected valid=%b queued=%0d", mvo, rsp_q.size());
        end else begin
          e   = rsp_q.pop_front();
          got = mvo[1] ? {1'b1, m1_data_o, m1_user_o, m1_err_o}
                       : {1'b0, m0_data_o, m0_user_o, m0_err_o};
          if (got !== e) begin
            failures++;
            $display("FAIL rsp_fields got=%h exp=%h", got, e);
          end
        end
      end
      checks++;
      if ((!m0_valid_o && {m0_data_o, m0_user_o, m0_err_o} !== '0) ||
          (!m1_valid_o && {m1_data_o, m1_user_o, m1_err_o} !== '0)) begin
        failures++;
        $display("FAIL idle_master_outputs m0=%h/%h/%b m1=%h/%h/%b",
                 m0_data_o, m0_user_o, m0_err_o, m1_data_o, m1_user_o, m1_err_o);
      end
      checks++;
      if (mem_valid_o) begin
        mg = {mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o};
        if (mreq_q.size() == 0) begin
          failures++;
          $display("FAIL mem_req_unexpected got=%h", mg);
        end else begin
          me = mreq_q.pop_front();
          if (mg !== me) begin
            failures++;
            $display("FAIL mem_req_fields got=%h exp=%h", mg, me);
          end
        end
      end else if ({mem_read_o, mem_write_o, mem_addr_o, mem_data_o, mem_user_o} !== '0) begin
        failures++;
        $display("FAIL mem_idle_outputs rd=%b wr=%b addr=%h", mem_read_o, mem_write_o, mem_addr_o);
      end
    end
  endtask

  task automatic test_reset();
    cyc(); set_req(0, 1'b1, 1'b0, 32'h0000_0040, '0, 32'h1);
    smp();
    checks++;
    if (mready !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", mready); end
    checks++;
    if (mvo !== 2'b00 || merr !== 2'b00) begin
      failures++; $display("FAIL reset_rsp valid=%b err=%b exp=00/00", mvo, merr);
    end
    checks++;
    if (mem_valid_o !== 1'b0) begin failures++; $display("FAIL reset_mem_valid got=%b exp=0", mem_valid_o); end
    cyc(); clr_req(0); cpu_reset = 1'b0;
    smp();
  endtask

  task automatic test_single_read();
    cyc(); set_req(0, 1'b1, 1'b0, 32'h4000_0004, '0, 32'h11);
    mreq_q.push_back({1'b1, 1'b0, 32'h4000_0004, 32'h0, 32'h11});
    rsp_q.push_back({1'b0, 32'hDEAD_BEEF, 32'h77, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b01) begin failures++; $display("FAIL read_accept got=%b exp=01", mready); end
    cyc(); clr_req(0);
    smp();
    checks++;
    if (mem_valid_o !== 1'b1 || mready !== 2'b00) begin
      failures++; $display("FAIL read_issue_n1 mem_valid=%b ready=%b exp=1/00", mem_valid_o, mready);
    end
    cyc(); mem_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF; mem_user_i = 32'h77;
    smp();
    checks++;
    if (mvo !== 2'b00) begin failures++; $display("FAIL read_early_rsp got=%b exp=00", mvo); end
    cyc(); mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    smp();
    checks++;
    if (mvo !== 2'b01 || m0_data_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL read_rsp_n3 valid=%b data=%h exp=01/deadbeef", mvo, m0_data_o);
    end
    cyc(); smp();
    checks++;
    if (mvo !== 2'b00 || mem_valid_o !== 1'b0) begin
      failures++; $display("FAIL read_pulse_len valid=%b mem_valid=%b exp=00/0", mvo, mem_valid_o);
    end
  endtask

  task automatic test_contention();
    do_reset();
    cyc();
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, '0, 32'h1);
    set_req(1, 1'b1, 1'b0, 32'h0000_0200, '0, 32'h2);
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'h1});
    rsp_q.push_back({1'b0, 32'hA0A0_A0A0, 32'h51, 1'b0});
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h2});
    rsp_q.push_back({1'b1, 32'hB1B1_B1B1, 32'h52, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b01) begin failures++; $display("FAIL rr_first got=%b exp=01", mready); end
    serve(2'b01, 32'hA0A0_A0A0, 32'h51);
    cyc(); smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL rr_second_n4 got=%b exp=10", mready); end
    serve(2'b10, 32'hB1B1_B1B1, 32'h52);
    cyc();
    set_req(0, 1'b1, 1'b0, 32'h0000_0300, '0, 32'h3);
    set_req(1, 1'b1, 1'b0, 32'h0000_0400, '0, 32'h4);
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h3});
    rsp_q.push_back({1'b0, 32'hC0C0_C0C0, 32'h53, 1'b0});
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0400, 32'h0, 32'h4});
    rsp_q.push_back({1'b1, 32'hD1D1_D1D1, 32'h54, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b01) begin failures++; $display("FAIL rr_third got=%b exp=01", mready); end
    serve(2'b01, 32'hC0C0_C0C0, 32'h53);
    cyc(); smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL rr_fourth got=%b exp=10", mready); end
    serve(2'b10, 32'hD1D1_D1D1, 32'h54);
  endtask

  task automatic test_write();
    cyc(); set_req(1, 1'b0, 1'b1, 32'h2000_0010, 32'h1234_5678, 32'hA5);
    mreq_q.push_back({1'b0, 1'b1, 32'h2000_0010, 32'h1234_5678, 32'hA5});
    rsp_q.push_back({1'b1, 32'h0, 32'hA5, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL write_accept got=%b exp=10", mready); end
    // Stray memory strobe during ISSUE must not complete the transaction.
    cyc(); clr_req(1); mem_valid_i = 1'b1; mem_data_i = 32'hBAD0_BAD0; mem_user_i = 32'hFF;
    smp();
    checks++;
    if (mem_write_o !== 1'b1 || mem_data_o !== 32'h1234_5678) begin
      failures++; $display("FAIL write_issue wr=%b data=%h exp=1/12345678", mem_write_o, mem_data_o);
    end
    cyc(); mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    smp();
    cyc(); smp();
    checks++;
    if (mvo !== 2'b00) begin failures++; $display("FAIL write_waits_ack got=%b exp=00", mvo); end
    cyc(); mem_valid_i = 1'b1; mem_data_i = 32'h0; mem_user_i = 32'hA5;
    smp();
    cyc(); mem_valid_i = 1'b0; mem_user_i = '0;
    smp();
    checks++;
    if (mvo !== 2'b10 || m1_user_o !== 32'hA5) begin
      failures++; $display("FAIL write_rsp valid=%b user=%h exp=10/a5", mvo, m1_user_o);
    end
  endtask

  task automatic test_timeout();
    cyc(); set_req(0, 1'b1, 1'b0, 32'h0000_0000, '0, 32'h3C);
    mreq_q.push_back({1'b1, 1'b0, 32'h0, 32'h0, 32'h3C});
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    rsp_q.push_back({1'b0, 32'h0, 32'h3C, 1'b1});
`endif
    smp();
    checks++;
    if (mready !== 2'b01) begin failures++; $display("FAIL tmo_accept got=%b exp=01", mready); end
    cyc(); clr_req(0); set_req(1, 1'b1, 1'b0, 32'h0000_0500, '0, 32'h9);
    smp();
`ifdef W0RM_MEM_ARB_TIMEOUT_EN
    for (int i = 0; i < TO; i++) begin
      cyc(); smp();
      checks++;
      if (mvo !== 2'b00 || mready !== 2'b00) begin
        failures++; $display("FAIL tmo_wait_%0d valid=%b ready=%b exp=00/00", i, mvo, mready);
      end
    end
    cyc(); smp();
    checks++;
    if (mvo !== 2'b01 || merr !== 2'b01 || m0_data_o !== 32'h0) begin
      failures++; $display("FAIL tmo_err valid=%b err=%b data=%h exp=01/01/0", mvo, merr, m0_data_o);
    end
`else
    for (int i = 0; i < 40; i++) begin
      cyc(); smp();
      checks++;
      if (mvo !== 2'b00 || mready !== 2'b00) begin
        failures++; $display("FAIL hold_wait_%0d valid=%b ready=%b exp=00/00", i, mvo, mready);
      end
    end
    cyc(); mem_valid_i = 1'b1; mem_data_i = 32'hF0F0_F0F0; mem_user_i = 32'h62;
    rsp_q.push_back({1'b0, 32'hF0F0_F0F0, 32'h62, 1'b0});
    smp();
    cyc(); mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    smp();
    checks++;
    if (mvo !== 2'b01 || merr !== 2'b00 || m0_data_o !== 32'hF0F0_F0F0) begin
      failures++; $display("FAIL hold_rsp valid=%b err=%b data=%h exp=01/00/f0f0f0f0", mvo, merr, m0_data_o);
    end
`endif
    cyc();
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h9});
    rsp_q.push_back({1'b1, 32'hE1E1_E1E1, 32'h61, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL tmo_next_accept got=%b exp=10", mready); end
    serve(2'b10, 32'hE1E1_E1E1, 32'h61);
  endtask

  task automatic test_reset_mid();
    cyc(); set_req(1, 1'b1, 1'b0, 32'h0000_0600, '0, 32'h71);
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0600, 32'h0, 32'h71});
    smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL rmid_accept got=%b exp=10", mready); end
    cyc(); clr_req(1);
    smp();
    cyc(); cpu_reset = 1'b1;
    smp();
    cyc(); cpu_reset = 1'b0; mem_valid_i = 1'b1; mem_data_i = 32'hBAD_BAD; mem_user_i = 32'hEE;
    smp();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (mvo !== 2'b00) begin failures++; $display("FAIL rmid_no_rsp_%0d got=%b exp=00", i, mvo); end
      cyc(); mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
      smp();
    end
    cyc();
    set_req(0, 1'b1, 1'b0, 32'h0000_0700, '0, 32'h72);
    set_req(1, 1'b1, 1'b0, 32'h0000_0800, '0, 32'h73);
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0700, 32'h0, 32'h72});
    rsp_q.push_back({1'b0, 32'h7777_7777, 32'h74, 1'b0});
    mreq_q.push_back({1'b1, 1'b0, 32'h0000_0800, 32'h0, 32'h73});
    rsp_q.push_back({1'b1, 32'h8888_8888, 32'h75, 1'b0});
    smp();
    checks++;
    if (mready !== 2'b01) begin failures++; $display("FAIL rmid_after_accept got=%b exp=01", mready); end
    serve(2'b01, 32'h7777_7777, 32'h74);
    cyc(); smp();
    checks++;
    if (mready !== 2'b10) begin failures++; $display("FAIL rmid_alt got=%b exp=10", mready); end
    serve(2'b10, 32'h8888_8888, 32'h75);
    cyc(); smp();
  endtask

  initial begin
    cpu_reset = 1'b1;
    mv = '0; mrd = '0; mwr = '0;
    for (int i = 0; i < 2; i++) begin
      maddr[i] = '0; mwdata[i] = '0; muser[i] = '0;
    end
    mem_valid_i = 1'b0; mem_data_i = '0; mem_user_i = '0;
    fork
      monitor();
    join_none
    test_reset();
    test_single_read();
    test_contention();
    test_write();
    test_timeout();
    test_reset_mid();
    checks++;
    if (rsp_q.size() != 0 || mreq_q.size() != 0) begin
      failures++;
      $display("FAIL drain rsp_left=%0d mem_req_left=%0d exp=0/0", rsp_q.size(), mreq_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog sim_time=%0t limit=200000", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
